// File: rtl/bridge.sv
// bridge: system bridge between the CPU data port and memory-mapped peripherals
// (timer/counter, 32-bit input port, 32-bit output port).
//
// The address is split into a high field, a device ID and an in-device offset.
// A device is selected only when the high field is zero and the ID matches.
// Read data is muxed back from the selected device; write data and offset are
// broadcast to all devices; write strobes are gated per device.
//
// Ports:
//   clk, reset            system clock (rising edge), synchronous active-high reset
//   PrAddr, PrWD, Wen     CPU byte address, write data, write request
//   PrRD                  read data returned to the CPU (0 when unmapped)
//   DevAddr, DevWD        in-device offset and write data to all devices
//   DevWr                 per-device write strobe {OUT32, IN32, TC}
//   DevRDTC/IN32/OUT32    read data from each device
//   BusErr, ErrAddr       sticky unmapped-write flag and address of the first one
module bridge #(
    parameter int unsigned          DEV_ADDR_WD = 4,
    parameter int unsigned          DEV_ID_WD   = 4,
    parameter logic [DEV_ID_WD-1:0] DEV_TC      = 4'h1,
    parameter logic [DEV_ID_WD-1:0] DEV_IN32    = 4'h2,
    parameter logic [DEV_ID_WD-1:0] DEV_OUT32   = 4'h3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            PrAddr,
    input  logic [31:0]            PrWD,
    input  logic                   Wen,
    output logic [31:0]            PrRD,
    output logic [DEV_ADDR_WD:1]   DevAddr,
    output logic [31:0]            DevWD,
    output logic [2:0]             DevWr,
    input  logic [31:0]            DevRDTC,
    input  logic [31:0]            DevRDIN32,
    input  logic [31:0]            DevRDOUT32,
    output logic                   BusErr,
    output logic [31:0]            ErrAddr
);

    localparam int unsigned HI_LSB = DEV_ADDR_WD + DEV_ID_WD;

    logic [DEV_ID_WD-1:0] id;
    logic                 hi_zero;
    logic                 hit_tc;
    logic                 hit_in32;
    logic                 hit_out32;
    logic                 any_hit;

    assign id        = PrAddr[HI_LSB-1:DEV_ADDR_WD];
    assign hi_zero   = (PrAddr[31:HI_LSB] == '0);
    assign hit_tc    = hi_zero && (id == DEV_TC);
    assign hit_in32  = hi_zero && (id == DEV_IN32);
    assign hit_out32 = hi_zero && (id == DEV_OUT32);
    assign any_hit   = hit_tc || hit_in32 || hit_out32;

    // Offset and write data are broadcast unconditionally; only the strobes
    // qualify which device acts, so the read data never feeds these outputs.
    assign DevAddr = PrAddr[DEV_ADDR_WD-1:0];
    assign DevWD   = PrWD;
    assign DevWr   = {Wen & hit_out32, Wen & hit_in32, Wen & hit_tc};

    always_comb begin
        PrRD = '0;
        if (hit_tc)
            PrRD = DevRDTC;
        else if (hit_in32)
            PrRD = DevRDIN32;
        else if (hit_out32)
            PrRD = DevRDOUT32;
    end

    // First unmapped write since reset wins; later ones are ignored while set.
    always_ff @(posedge clk) begin
        if (reset) begin
            BusErr  <= 1'b0;
            ErrAddr <= '0;
        end else if (Wen && !any_hit && !BusErr) begin
            BusErr  <= 1'b1;
            ErrAddr <= PrAddr;
        end
    end

endmodule

// File: tb/tb_bridge.sv
// tb_bridge: self-checking bench for bridge. A table of directed vectors covers
// the address decode, hand-written sequences cover the sticky error capture,
// and a randomized phase compares against an arithmetic reference model.
module tb_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic        Wen;
    logic [31:0] PrRD;
    logic [4:1]  DevAddr;
    logic [31:0] DevWD;
    logic [2:0]  DevWr;
    logic [31:0] DevRDTC;
    logic [31:0] DevRDIN32;
    logic [31:0] DevRDOUT32;
    logic        BusErr;
    logic [31:0] ErrAddr;

    int total = 0;
    int bad   = 0;

    bridge #(
        .DEV_ADDR_WD(4),
        .DEV_ID_WD  (4),
        .DEV_TC     (4'h1),
        .DEV_IN32   (4'h2),
        .DEV_OUT32  (4'h3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .PrAddr    (PrAddr),
        .PrWD      (PrWD),
        .Wen       (Wen),
        .PrRD      (PrRD),
        .DevAddr   (DevAddr),
        .DevWD     (DevWD),
        .DevWr     (DevWr),
        .DevRDTC   (DevRDTC),
        .DevRDIN32 (DevRDIN32),
        .DevRDOUT32(DevRDOUT32),
        .BusErr    (BusErr),
        .ErrAddr   (ErrAddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] rd;
        logic [3:0]  daddr;
        logic [2:0]  wr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: the address is viewed as block number (addr / 16) and
    // offset (addr % 16); blocks 1, 2, 3 are TC, IN32, OUT32.
    function automatic int unsigned ref_dev(input logic [31:0] a);
        int unsigned blk;
        blk = a / 16;
        if (blk >= 1 && blk <= 3) return blk;
        return 0;
    endfunction

    task automatic drive(input logic [31:0] a, input logic w);
        @(negedge clk);
        PrAddr = a;
        Wen    = w;
        #1;
    endtask

    vec_t vecs[12];
    logic        m_err;
    logic [31:0] m_addr;

    initial begin
        reset      = 1'b1;
        PrAddr     = '0;
        PrWD       = 32'hfedc4321;
        Wen        = 1'b0;
        DevRDTC    = 32'h12345678;
        DevRDIN32  = 32'h8765fedc;
        DevRDOUT32 = 32'h89abcdef;

        vecs[0]  = '{32'h15,       1'b0, 32'h12345678, 4'h5, 3'b000};
        vecs[1]  = '{32'h27,       1'b0, 32'h8765fedc, 4'h7, 3'b000};
        vecs[2]  = '{32'h3f,       1'b0, 32'h89abcdef, 4'hf, 3'b000};
        vecs[3]  = '{32'h13,       1'b0, 32'h12345678, 4'h3, 3'b000};
        vecs[4]  = '{32'h22,       1'b0, 32'h8765fedc, 4'h2, 3'b000};
        vecs[5]  = '{32'h3e,       1'b0, 32'h89abcdef, 4'he, 3'b000};
        vecs[6]  = '{32'h13,       1'b1, 32'h12345678, 4'h3, 3'b001};
        vecs[7]  = '{32'h22,       1'b1, 32'h8765fedc, 4'h2, 3'b010};
        vecs[8]  = '{32'h3e,       1'b1, 32'h89abcdef, 4'he, 3'b100};
        vecs[9]  = '{32'h45,       1'b1, 32'h0,        4'h5, 3'b000};
        vecs[10] = '{32'h1000015,  1'b1, 32'h0,        4'h5, 3'b000};
        vecs[11] = '{32'h05,       1'b1, 32'h0,        4'h5, 3'b000};

        // Reset held high: combinational outputs must still follow inputs,
        // and unmapped writes in the table must not raise the error flag.
        @(posedge clk);
        #1;
        chk("reset_buserr", {31'b0, BusErr}, 32'h0);
        chk("reset_erraddr", ErrAddr, 32'h0);
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].addr, vecs[i].wen);
            chk($sformatf("tbl%0d_prrd", i), PrRD, vecs[i].rd);
            chk($sformatf("tbl%0d_devaddr", i), {28'b0, DevAddr}, {28'b0, vecs[i].daddr});
            chk($sformatf("tbl%0d_devwd", i), DevWD, 32'hfedc4321);
            chk($sformatf("tbl%0d_devwr", i), {29'b0, DevWr}, {29'b0, vecs[i].wr});
        end
        @(posedge clk);
        #1;
        chk("tbl_buserr_in_reset", {31'b0, BusErr}, 32'h0);

        // Error capture sequence.
        drive(32'h0, 1'b0);
        reset = 1'b0;
        drive(32'h13, 1'b1);
        @(posedge clk); #1;
        chk("mapped_wr_no_err", {31'b0, BusErr}, 32'h0);
        drive(32'h45, 1'b0);
        @(posedge clk); #1;
        chk("unmapped_rd_no_err", {31'b0, BusErr}, 32'h0);
        drive(32'h45, 1'b1);
        @(posedge clk); #1;
        chk("err_set", {31'b0, BusErr}, 32'h1);
        chk("err_addr", ErrAddr, 32'h45);
        drive(32'h55, 1'b1);
        @(posedge clk); #1;
        chk("err_sticky", {31'b0, BusErr}, 32'h1);
        chk("err_first_wins", ErrAddr, 32'h45);
        drive(32'h15, 1'b0);
        @(posedge clk); #1;
        chk("err_hold", ErrAddr, 32'h45);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("err_clr_flag", {31'b0, BusErr}, 32'h0);
        chk("err_clr_addr", ErrAddr, 32'h0);

        // Randomized phase against the reference model.
        m_err  = 1'b0;
        m_addr = '0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic        w;
            int unsigned d;
            int unsigned r;
            logic [31:0] exp_rd;
            r = $urandom_range(0, 9);
            if (r == 0)
                a = $urandom;
            else
                a = $urandom_range(0, 95);
            if (r == 9)
                a = a | (32'h1 << $urandom_range(8, 31));
            w = 1'($urandom_range(0, 1));
            @(negedge clk);
            reset      = ($urandom_range(0, 29) == 0);
            PrWD       = $urandom;
            DevRDTC    = $urandom;
            DevRDIN32  = $urandom;
            DevRDOUT32 = $urandom;
            PrAddr     = a;
            Wen        = w;
            #1;
            d = ref_dev(a);
            exp_rd = (d == 1) ? DevRDTC : (d == 2) ? DevRDIN32 : (d == 3) ? DevRDOUT32 : 32'h0;
            chk("rnd_prrd", PrRD, exp_rd);
            chk("rnd_devaddr", {28'b0, DevAddr}, a % 16);
            chk("rnd_devwd", DevWD, PrWD);
            chk("rnd_devwr", {29'b0, DevWr}, (w && d != 0) ? (32'h1 << (d - 1)) : 32'h0);
            @(posedge clk);
            if (reset) begin
                m_err  = 1'b0;
                m_addr = '0;
            end else if (w && d == 0 && !m_err) begin
                m_err  = 1'b1;
                m_addr = a;
            end
            #1;
            chk("rnd_buserr", {31'b0, BusErr}, {31'b0, m_err});
            chk("rnd_erraddr", ErrAddr, m_addr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
